sram_scan_driver: RTL
=====================

SRAM_SCAN_DRIVER -- requirements
Module: sram_scan_driver

Interface
REQ-001 SHALL have parameter N_ADDR, default 32, address width of scan header.
REQ-002 SHALL have parameter N_DATA, default 32, data word width.
REQ-003 SHALL have parameter RST_CYC, default 4, scan_clk cycles `sram_rst_n_o` is held low before each transaction.
REQ-004 SHALL have parameter RD_LAT, default 34, scan_clk cycles from last header bit to first sampled read bit.
REQ-005 SHALL have the following ports:
- `scan_clk` in 1: sole clock.
- `scan_rst_n` in 1: reset; asynchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_addr` in N_ADDR: start address.
- `cmd_cnt` in 32: word count.
- `cmd_write` in 1: 1 = write, 0 = read.
- `wdata_valid` in 1 / `wdata_ready` out 1: write-word handshake.
- `wdata` in N_DATA: write word.
- `rdata_valid` out 1: one-cycle read-word strobe.
- `rdata` out N_DATA: read word.
- `done` out 1: one-cycle end-of-transaction pulse.
- `underrun` out 1: sticky write-starvation flag.
- `sram_rst_n_o` out 1: drives the scan wrapper reset.
- `scan_data_o` out 1: serial stream to the wrapper scan input.
- `scan_data_i` in 1: serial stream from the wrapper scan output.

Function
REQ-006 SHALL implement FSM states IDLE, RST, HDR, WR, RDW, RD, DONE; all registers update on posedge scan_clk.
REQ-007 IDLE SHALL assert `cmd_ready`; on `cmd_valid` && `cmd_ready` it SHALL latch addr/cnt/write and go to RST.
REQ-008 RST SHALL drive `sram_rst_n_o`=0 and `scan_data_o`=0 for RST_CYC cycles, then go to HDR.
REQ-009 HDR SHALL shift out 1+32+N_ADDR bits, one per cycle, ordered: write bit, then cnt LSB-first, then addr LSB-first.
REQ-010 After HDR: cnt==0 -> DONE; write -> WR; read -> RDW.
REQ-011 WR SHALL shift each word LSB-first over exactly N_DATA cycles, back-to-back, for cnt words.
REQ-012 WR SHALL assert `wdata_ready` only in the last bit-cycle of the prior word (or the last HDR cycle for word 0); the word is consumed on the handshake.
REQ-013 If `wdata_valid`=0 at the consume cycle, the driver SHALL shift an all-zero word, set `underrun`, and keep the word count advancing (wrapper timing is free-running).
REQ-014 RDW SHALL wait RD_LAT cycles, then RD SHALL sample `scan_data_i` each cycle into an LSB-first shift register.
REQ-015 `rdata_valid` SHALL pulse on the cycle after the N_DATA-th bit of each word, with `rdata` stable until the next pulse; RD SHALL exit to DONE after cnt words.
REQ-016 DONE SHALL pulse `done` for one cycle, then return to IDLE; `scan_data_o`=0 outside HDR/WR.
REQ-017 `sram_rst_n_o` SHALL be 1 in all states except RST and reset.
REQ-018 The word counter SHALL be 32 bits; cnt=0xFFFFFFFF SHALL run to completion without wrap.
REQ-019 `cmd_valid` asserted while busy SHALL be ignored (`cmd_ready`=0); no queueing.
REQ-020 `underrun` SHALL clear only on acceptance of a new command.

Reset
REQ-021 `scan_rst_n` low SHALL force IDLE asynchronously and zero all counters and outputs, except `sram_rst_n_o`=0 and `cmd_ready`=1 (the latter after deassertion).
REQ-022 Reset mid-transaction SHALL abort with no `done`/`rdata_valid` pulse; the next command restarts from RST.

Structure
REQ-023 State enum, header length (1+32+N_ADDR) and the bit-order constants SHALL live in shared package `sram_scan_pkg`, reused by the wrapper bench.
REQ-024 The serializer/deserializer SHALL be one sub-module, `scan_shift_reg` (parallel load, serial out, serial in, parallel out, N_DATA wide).

Verification
REQ-025 Write addr=0x10, cnt=1, wdata=0xDEADBEEF -> after 4 RST cycles, 65 header bits {1, cnt LSB-first, 0x10 LSB-first}, then 0xDEADBEEF LSB-first, then `done`.
REQ-026 Write cnt=3 with `wdata_valid` low for word 2 -> word 2 shifted as 0, `underrun`=1, `done` still pulses after 3 words.
REQ-027 Read cnt=2 against the wrapper preloaded with 0x12345678 and 0xCAFEF00D -> two `rdata_valid` pulses with those values in order.
REQ-028 cnt=0 read -> header only, `done` pulse 66 cycles after RST ends, no `rdata_valid`.
REQ-029 `scan_rst_n` asserted mid-WR -> outputs reset immediately, no `done`; a following write cnt=1 completes correctly.
REQ-030 `cmd_valid` held during a busy transaction -> `cmd_ready`=0, and the second command is accepted only in IDLE.

Source files
------------

// File: rtl/sram_scan_pkg.sv
// Shared definitions for the SRAM scan driver and anything that talks to the
// same scan wrapper: controller state encoding, header layout and word-count
// width.
//
// Header layout, shifted out bit 0 first:
//   bit 0                       : write flag
//   bits HDR_CNT_POS +: CNT_W   : word count, LSB first
//   bits HDR_ADDR_POS +: n_addr : start address, LSB first
package sram_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_HDR,
    S_WR,
    S_RDW,
    S_RD,
    S_DONE
  } scan_state_t;

  localparam int CNT_W        = 32;
  localparam int HDR_WR_POS   = 0;
  localparam int HDR_CNT_POS  = HDR_WR_POS + 1;
  localparam int HDR_ADDR_POS = HDR_CNT_POS + CNT_W;

  function automatic int hdr_len(input int n_addr);
    return HDR_ADDR_POS + n_addr;
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Word-wide shift register shared by the write serializer and the read
// deserializer. Shifts right: the serial output is bit 0 and the serial
// input enters at the MSB, so a word travels LSB first in both directions.
//
// Ports:
//   clk       : clock
//   load      : parallel load (takes priority over shift)
//   load_data : word to load
//   shift     : shift one position this cycle
//   si        : serial input, enters at the MSB
//   so        : serial output, bit 0
//   pout      : parallel output including the bit being shifted in this
//               cycle, so a word can be captured on the same edge that
//               samples its last bit
module scan_shift_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              si,
  output logic              so,
  output logic [DATA_W-1:0] pout
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {si, q[DATA_W-1:1]};
    end
  end

  assign so   = q[0];
  assign pout = {si, q[DATA_W-1:1]};

endmodule

// File: rtl/sram_scan_driver.sv
// Drives an SRAM scan wrapper: per command it pulses the wrapper reset,
// shifts out a header (write flag, count, address), then streams write
// words out or, after a fixed latency, samples read words back in.
// The wrapper timing is free-running, so once a transaction starts it never
// stalls; a missing write word is replaced by zero and flagged.
//
// Ports:
//   scan_clk, scan_rst_n          : clock, async active-low reset
//   cmd_valid/cmd_ready           : command handshake (accepted only when idle)
//   cmd_addr, cmd_cnt, cmd_write  : start address, word count, direction
//   wdata_valid/wdata_ready/wdata : write word handshake
//   rdata_valid, rdata            : read word strobe and held word
//   done                          : one-cycle end-of-transaction pulse
//   underrun                      : sticky, a write word was missing
//   sram_rst_n_o                  : wrapper reset
//   scan_data_o, scan_data_i      : serial stream to / from the wrapper
//
// RST_CYC and RD_LAT must be at least 1; N_DATA at least 2.
module sram_scan_driver
  import sram_scan_pkg::*;
#(
  parameter int N_ADDR  = 32,
  parameter int N_DATA  = 32,
  parameter int RST_CYC = 4,
  parameter int RD_LAT  = 34
) (
  input  logic              scan_clk,
  input  logic              scan_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N_ADDR-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              cmd_write,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [N_DATA-1:0] wdata,
  output logic              rdata_valid,
  output logic [N_DATA-1:0] rdata,
  output logic              done,
  output logic              underrun,
  output logic              sram_rst_n_o,
  output logic              scan_data_o,
  input  logic              scan_data_i
);

  localparam int          HDR_LEN   = hdr_len(N_ADDR);
  localparam logic [31:0] RST_LAST  = 32'(RST_CYC - 1);
  localparam logic [31:0] HDR_LAST  = 32'(HDR_LEN - 1);
  localparam logic [31:0] WORD_LAST = 32'(N_DATA - 1);
  localparam logic [31:0] RDW_LAST  = 32'(RD_LAT - 1);

  scan_state_t state, next_state;

  logic [31:0]        step;
  logic [31:0]        step_end;
  logic               step_last;
  logic [CNT_W-1:0]   words_left;
  logic               write_q;
  logic [HDR_LEN-1:0] hdr_sr;
  logic               accept;
  logic               word_end;
  logic               last_word;

  logic               sr_load;
  logic               sr_shift;
  logic               sr_si;
  logic               sr_so;
  logic [N_DATA-1:0]  sr_load_data;
  logic [N_DATA-1:0]  sr_pout;

  assign accept    = cmd_valid & cmd_ready;
  assign last_word = (words_left == CNT_W'(1));
  assign step_last = (step == step_end);
  assign word_end  = ((state == S_WR) || (state == S_RD)) && step_last;

  // Length of the current state (or of one word in WR/RD), as a last index.
  always_comb begin
    step_end = '0;
    case (state)
      S_RST:       step_end = RST_LAST;
      S_HDR:       step_end = HDR_LAST;
      S_WR, S_RD:  step_end = WORD_LAST;
      S_RDW:       step_end = RDW_LAST;
      default:     step_end = '0;
    endcase
  end

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    wdata_ready = 1'b0;
    done        = 1'b0;
    scan_data_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) next_state = S_RST;
      end
      S_RST: begin
        if (step_last) next_state = S_HDR;
      end
      S_HDR: begin
        scan_data_o = hdr_sr[0];
        if (step_last) begin
          if (words_left == '0) begin
            next_state = S_DONE;
          end else if (write_q) begin
            // Word 0 is fetched on the last header bit so it starts
            // shifting with no gap.
            next_state  = S_WR;
            wdata_ready = 1'b1;
          end else begin
            next_state = S_RDW;
          end
        end
      end
      S_WR: begin
        scan_data_o = sr_so;
        if (word_end) begin
          if (last_word) next_state = S_DONE;
          else           wdata_ready = 1'b1;
        end
      end
      S_RDW: begin
        if (step_last) next_state = S_RD;
      end
      S_RD: begin
        if (word_end && last_word) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      step         <= '0;
      words_left   <= '0;
      write_q      <= 1'b0;
      cmd_ready    <= 1'b0;
      sram_rst_n_o <= 1'b0;
      underrun     <= 1'b0;
      rdata_valid  <= 1'b0;
      rdata        <= '0;
    end else begin
      // Every state change lands on step_last, so one wrap rule covers
      // both per-state timing and per-word bit counting.
      step <= step_last ? '0 : step + 32'd1;

      if (accept) begin
        words_left <= cmd_cnt;
        write_q    <= cmd_write;
        underrun   <= 1'b0;
      end else begin
        if (word_end) words_left <= words_left - CNT_W'(1);
        if (wdata_ready && !wdata_valid) underrun <= 1'b1;
      end

      // Registered from next_state so both track the state with no glitch
      // and both hold their reset level until the first clock after reset.
      cmd_ready    <= (next_state == S_IDLE);
      sram_rst_n_o <= (next_state != S_RST);

      rdata_valid <= (state == S_RD) && step_last;
      if ((state == S_RD) && step_last) rdata <= sr_pout;
    end
  end

  always_ff @(posedge scan_clk) begin
    if (accept) begin
      hdr_sr <= {cmd_addr, cmd_cnt, cmd_write};
    end else if (state == S_HDR) begin
      hdr_sr <= hdr_sr >> 1;
    end
  end

  // A missing write word still occupies its N_DATA slots, as zeros.
  assign sr_load      = wdata_ready;
  assign sr_load_data = wdata_valid ? wdata : '0;
  assign sr_shift     = (state == S_WR) || (state == S_RD);
  assign sr_si        = (state == S_RD) && scan_data_i;

  scan_shift_reg #(
    .DATA_W (N_DATA)
  ) u_shift (
    .clk       (scan_clk),
    .load      (sr_load),
    .load_data (sr_load_data),
    .shift     (sr_shift),
    .si        (sr_si),
    .so        (sr_so),
    .pout      (sr_pout)
  );

endmodule
